spi_reg_slave: RTL
==================

Name: spi_reg_slave

Overview:
- SPI responder (register-file endpoint) for the 16-bit sensor register-access frame: 1 control bit (1=write, 0=read), then 7-bit address MSB-first, then 8-bit data MSB-first.
- Used as an on-FPGA sensor register model for loopback/bring-up of the SPI initiator, and as a fabric-side shadow of sensor configuration.
- SPI pins are asynchronous to FSM_Clk; the block oversamples them with synchronisers.

Parameters:
- NUM_REGS, 128, register count; address is 7 bits; addresses >= NUM_REGS read 0x00 and ignore writes.
- RESET_VAL, 8'h00, reset value of every register.
- RO_LIMIT, 4, addresses 0..RO_LIMIT-1 are read-only (used only with SPI_REG_RO_EN).

Ports:
- FSM_Clk  input  1  system clock; all state on rising edge.
- FSM_Rst  input  1  asynchronous, active-high reset.
- SPI_CLK  input  1  SPI clock from initiator; idles low.
- SPI_EN  input  1  frame enable, active high.
- SPI_IN  input  1  data from initiator, sampled on SPI_CLK rise.
- SPI_OUT  output  1  read data to initiator.
- spi_out_en  output  1  high while SPI_OUT is driving read data.
- lcl_addr  input  7  fabric read address.
- lcl_data  output  8  register[lcl_addr], registered, 1-cycle latency.
- wr_strobe  output  1  one-cycle pulse when a SPI write commits.
- wr_addr  output  7  address of the last committed write.
- wr_data  output  8  data of the last committed write.
- rd_strobe  output  1  one-cycle pulse when read data bit 7 is loaded.

Behaviour:
- Reset: all registers = RESET_VAL; SPI_OUT, spi_out_en, wr_strobe, rd_strobe = 0; wr_addr, wr_data, lcl_data = 0; state = IDLE; synchronisers cleared.
- SPI_CLK, SPI_EN and SPI_IN each pass through a 2-FF synchroniser. Rise/fall detect uses a third flop on SPI_CLK.
- Timing requirement: SPI_CLK high and low phases are each >= 4 FSM_Clk periods.
- The initiator changes SPI_IN on the SPI_CLK falling edge. The block samples SPI_IN on the detected rising edge.
- Bit counter bit_cnt (5b) counts detected rises within a frame and saturates at 16.
- States:
  - IDLE: wait for synced EN = 1 → CMD; clear bit_cnt and the shift register.
  - CMD: first rise latches is_write = SPI_IN → ADDR.
  - ADDR: seven rises shift in the address. On the 7th rise:
    - If read: load shift_out = reg[addr]; drive SPI_OUT = reg[addr][7] and spi_out_en = 1 in the next cycle; pulse rd_strobe.
    - Then → DATA.
  - DATA: eight rises.
    - Write: shift SPI_IN into data_sr.
    - Read: after each of the first 7 rises, shift shift_out left and present the next bit on SPI_OUT. SPI_OUT is updated 1 FSM_Clk after the detected rise, i.e. ≤ 4 FSM_Clk after the pin edge, well before the next sampling edge.
  - On the 8th DATA rise → DONE. If write, commit reg[addr] = data_sr in that cycle and pulse wr_strobe; wr_addr/wr_data update in the same cycle.
  - DONE: spi_out_en = 0, SPI_OUT = 0; further rises are ignored; synced EN = 0 → IDLE.
- Deasserting EN in any non-IDLE state → IDLE immediately: no commit, spi_out_en = 0, SPI_OUT = 0. A short frame is discarded.
- Falling edges change no state.
- A write commit and a lcl_addr read of the same address in the same cycle return the old value; the new value appears one cycle later.
- Asserting FSM_Rst mid-frame aborts the frame with no commit. A frame already in progress when reset releases is ignored until EN goes low, then high again.
- wr_strobe and rd_strobe are never asserted together.

Optional Feature:
- Macro: SPI_REG_RO_EN.
- Defined: writes to addresses < RO_LIMIT complete the frame and pulse wr_strobe, but leave the register unchanged; wr_data still reports the received byte.
- Undefined: all addresses below NUM_REGS are writable; RO_LIMIT is unused.

Decomposition:
- Shared package spi_reg_pkg:
  - FRAME_BITS = 16, ADDR_W = 7, DATA_W = 8.
  - State enum {IDLE, CMD, ADDR, DATA, DONE}.
  - CTRL_WRITE = 1'b1.
- One sub-module: spi_pin_sync, holding the 2-FF synchronisers plus the SPI_CLK rise/fall detector. Outputs: clk_rise, clk_fall, en_s, din_s.

Test Plan:
1. Write frame 1, 0x12, 0x5A (SPI half-period 4 FSM_Clk) → one wr_strobe pulse with wr_addr=0x12, wr_data=0x5A; lcl_addr=0x12 returns 0x5A one cycle later.
2. After test 1, read frame 0, 0x12 → SPI_OUT at the 8 data rises = 0,1,0,1,1,0,1,0; initiator captures 0x5A; one rd_strobe pulse; spi_out_en falls after the frame.
3. Write frame 1, 0x20, 0xFF with EN dropped after 10 rises → no wr_strobe; reg[0x20] stays 0x00; the next full frame works normally.
4. FSM_Rst pulsed at the 12th rise of write 0x30←0xA5 → reg[0x30] = 0x00, all outputs at reset values; subsequent write 0x30←0xA5 commits.
5. Back-to-back writes 0x01←0x11 then 0x02←0x22, with EN low 8 FSM_Clk between frames → two wr_strobes; readbacks 0x11 and 0x22 (with SPI_REG_RO_EN and RO_LIMIT=4: wr_strobe pulses twice, both registers stay 0x00).
6. Read of 0x7F with NUM_REGS=64 → SPI_OUT all zeros; a write to 0x7F leaves reg state unchanged.

Source files
------------

// File: rtl/spi_reg_pkg.sv
// spi_reg_pkg: shared frame widths, control encoding and FSM states for spi_reg_slave.
package spi_reg_pkg;
   localparam int FRAME_BITS = 16;
   localparam int ADDR_W = 7;
   localparam int DATA_W = 8;
   localparam logic CTRL_WRITE = 1'b1;
   typedef enum logic [2:0] {IDLE, CMD, ADDR, DATA, DONE} state_t;
endpackage

// File: rtl/spi_reg_slave_if.sv
// spi_reg_slave_if: SPI pin bundle between initiator (master) and register responder (slave).
interface spi_reg_slave_if;
   logic SPI_CLK;
   logic SPI_EN;
   logic SPI_IN;
   logic SPI_OUT;
   logic spi_out_en;
   modport master (output SPI_CLK, SPI_EN, SPI_IN, input SPI_OUT, spi_out_en);
   modport slave (input SPI_CLK, SPI_EN, SPI_IN, output SPI_OUT, spi_out_en);
endinterface

// File: rtl/spi_pin_sync.sv
// spi_pin_sync: 2-FF synchronisers for the SPI pins plus SPI_CLK edge detect.
module spi_pin_sync (
   input  logic FSM_Clk,
   input  logic FSM_Rst,
   input  logic spi_clk,
   input  logic spi_en,
   input  logic spi_in,
   output logic clk_rise,
   output logic clk_fall,
   output logic en_s,
   output logic din_s
);
   logic [2:0] ck;
   logic [1:0] en;
   logic [1:0] din;
   always_ff @(posedge FSM_Clk or posedge FSM_Rst) begin
      if (FSM_Rst) begin
         ck  <= '0;
         en  <= '0;
         din <= '0;
      end else begin
         ck  <= {ck[1:0], spi_clk};
         en  <= {en[0], spi_en};
         din <= {din[0], spi_in};
      end
   end
   assign clk_rise = ck[1] & ~ck[2];
   assign clk_fall = ~ck[1] & ck[2];
   assign en_s = en[1];
   assign din_s = din[1];
endmodule

// File: rtl/spi_reg_slave.sv
// spi_reg_slave: SPI register-file responder (W/R bit, 7b addr, 8b data).
// Define SPI_REG_RO_EN to make addresses below RO_LIMIT read-only.
module spi_reg_slave
   import spi_reg_pkg::*;
#(
   parameter int NUM_REGS = 128,
   parameter logic [DATA_W-1:0] RESET_VAL = 8'h00,
   parameter int RO_LIMIT = 4
) (
   input  logic FSM_Clk,
   input  logic FSM_Rst,
   spi_reg_slave_if.slave spi,
   input  logic [ADDR_W-1:0] lcl_addr,
   output logic [DATA_W-1:0] lcl_data,
   output logic wr_strobe,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [DATA_W-1:0] wr_data,
   output logic rd_strobe
);
   logic rise, clk_fall_unused, en_s, din_s;
   state_t state_q, state_d;
   logic [4:0] cnt_q, cnt_d;
   logic is_wr_q, is_wr_d, out_q, out_d, oen_q, oen_d, wrs_d, rds_d, commit, wr_ok;
   logic [ADDR_W-1:0] addr_q, addr_d, addr_nx;
   logic [DATA_W-1:0] data_q, data_d, data_nx, sh_q, sh_d, rd_word;
   logic [DATA_W-1:0] regs [2**ADDR_W];
   logic armed_q;
   logic [1:0] warm_q;

   spi_pin_sync u_sync (
      .FSM_Clk(FSM_Clk), .FSM_Rst(FSM_Rst),
      .spi_clk(spi.SPI_CLK), .spi_en(spi.SPI_EN), .spi_in(spi.SPI_IN),
      .clk_rise(rise), .clk_fall(clk_fall_unused), .en_s(en_s), .din_s(din_s)
   );

   assign addr_nx = {addr_q[ADDR_W-2:0], din_s};
   assign data_nx = {data_q[DATA_W-2:0], din_s};
   assign rd_word = (32'(addr_nx) < NUM_REGS) ? regs[addr_nx] : '0;
`ifdef SPI_REG_RO_EN
   assign wr_ok = (32'(addr_q) < NUM_REGS) && (32'(addr_q) >= RO_LIMIT);
`else
   logic unused_ro;
   assign unused_ro = ^RO_LIMIT;
   assign wr_ok = 32'(addr_q) < NUM_REGS;
`endif
   assign spi.SPI_OUT = out_q;
   assign spi.spi_out_en = oen_q;

   always_comb begin
      state_d = state_q;
      cnt_d = cnt_q;
      is_wr_d = is_wr_q;
      addr_d = addr_q;
      data_d = data_q;
      sh_d = sh_q;
      out_d = out_q;
      oen_d = oen_q;
      wrs_d = 1'b0;
      rds_d = 1'b0;
      commit = 1'b0;
      if (state_q != IDLE && !en_s) begin
         state_d = IDLE;
         out_d = 1'b0;
         oen_d = 1'b0;
      end else if (state_q == IDLE) begin
         cnt_d = '0;
         addr_d = '0;
         data_d = '0;
         sh_d = '0;
         if (armed_q && en_s) state_d = CMD;
      end else if (rise) begin
         cnt_d = (cnt_q == 5'(FRAME_BITS)) ? cnt_q : cnt_q + 5'd1;
         if (state_q == CMD) begin
            is_wr_d = din_s == CTRL_WRITE;
            state_d = ADDR;
         end else if (state_q == ADDR) begin
            addr_d = addr_nx;
            if (cnt_q == 5'(ADDR_W)) begin
               state_d = DATA;
               if (!is_wr_q) begin
                  sh_d = rd_word;
                  out_d = rd_word[DATA_W-1];
                  oen_d = 1'b1;
                  rds_d = 1'b1;
               end
            end
         end else if (state_q == DATA) begin
            data_d = data_nx;
            if (cnt_q == 5'(FRAME_BITS - 1)) begin
               state_d = DONE;
               out_d = 1'b0;
               oen_d = 1'b0;
               wrs_d = is_wr_q;
               commit = is_wr_q;
            end else if (!is_wr_q) begin
               sh_d = sh_q << 1;
               out_d = sh_q[DATA_W-2];
            end
         end
      end
   end

   // armed_q ignores a frame already in flight when reset releases
   always_ff @(posedge FSM_Clk or posedge FSM_Rst) begin
      if (FSM_Rst) begin
         state_q <= IDLE;
         cnt_q <= '0;
         is_wr_q <= 1'b0;
         addr_q <= '0;
         data_q <= '0;
         sh_q <= '0;
         out_q <= 1'b0;
         oen_q <= 1'b0;
         wr_strobe <= 1'b0;
         rd_strobe <= 1'b0;
         wr_addr <= '0;
         wr_data <= '0;
         lcl_data <= '0;
         armed_q <= 1'b0;
         warm_q <= '0;
         for (int i = 0; i < 2**ADDR_W; i++) regs[i] <= RESET_VAL;
      end else begin
         state_q <= state_d;
         cnt_q <= cnt_d;
         is_wr_q <= is_wr_d;
         addr_q <= addr_d;
         data_q <= data_d;
         sh_q <= sh_d;
         out_q <= out_d;
         oen_q <= oen_d;
         wr_strobe <= wrs_d;
         rd_strobe <= rds_d;
         warm_q <= {warm_q[0], 1'b1};
         armed_q <= armed_q | (warm_q[1] & ~en_s);
         lcl_data <= (32'(lcl_addr) < NUM_REGS) ? regs[lcl_addr] : '0;
         if (commit) begin
            wr_addr <= addr_q;
            wr_data <= data_nx;
            if (wr_ok) regs[addr_q] <= data_nx;
         end
      end
   end
endmodule
